// File: rtl/fractal_sync_pkg.sv
// Shared fractal sync definitions: tx drain defaults, channel state encoding and
// the per-node timeout status aggregate.
package fractal_sync_pkg;

  localparam int unsigned FSYNC_TX_TIMEOUT_DFLT = 1024;

  typedef enum logic {
    TX_DRAIN_IDLE = 1'b0,
    TX_DRAIN_FULL = 1'b1
  } fsync_tx_drain_state_e;

  typedef struct packed {
    logic en;
    logic ws;
  } fsync_tx_status_t;

endpackage

// File: rtl/fractal_sync_tx_drain_ch.sv
// One tx drain channel: pops the response FIFO into a registered valid/ready
// output and runs a sticky stall watchdog on the held response.
module fractal_sync_tx_drain_ch
  import fractal_sync_pkg::*;
#(
  parameter type         fsync_rsp_t    = logic,
  parameter int unsigned TIMEOUT_CYCLES = FSYNC_TX_TIMEOUT_DFLT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       empty_i,
  input  fsync_rsp_t rsp_i,
  output logic       pop_o,
  output fsync_rsp_t rsp_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       timeout_o,
  input  logic       clr_timeout_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  // Handshake: a response transfers in any cycle where valid_o && ready_i;
  // rsp_o is held stable while valid_o && !ready_i, ready_i is ignored when !valid_o.
  fsync_tx_drain_state_e state_q, state_d;
  fsync_rsp_t            rsp_q, rsp_d;
  logic                  pop;

  assign valid_o = (state_q == TX_DRAIN_FULL);
  assign rsp_o   = rsp_q;
  // Reset gates the pop so the FIFO is never drained into a register held in reset.
  assign pop     = rst_ni && !empty_i && (!valid_o || ready_i);
  assign pop_o   = pop;

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    if (pop) begin
      state_d = TX_DRAIN_FULL;
      rsp_d   = rsp_i;
    end else if (valid_o && ready_i) begin
      state_d = TX_DRAIN_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TX_DRAIN_IDLE;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
    end
  end

  if (TIMEOUT_CYCLES == 0) begin : g_no_wdog
    assign timeout_o = 1'b0;
  end else begin : g_wdog
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             stall;

    assign stall     = valid_o && !ready_i;
    assign timeout_o = timeout_q;

    // The counter survives a flag clear, so a still-saturated stall re-arms the flag.
    always_comb begin
      cnt_d     = '0;
      timeout_d = timeout_q;
      if (stall) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
      if (stall && (cnt_d == CNT_MAX)) begin
        timeout_d = 1'b1;
      end
      if (clr_timeout_i) begin
        timeout_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q     <= '0;
        timeout_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        timeout_q <= timeout_d;
      end
    end
  end

endmodule

// File: rtl/fractal_sync_tx_drain.sv
// Tx drain for the en and ws response FIFOs: two independent channels sharing
// only the clock, reset and the timeout clear.
module fractal_sync_tx_drain
  import fractal_sync_pkg::*;
#(
  parameter type         fsync_rsp_t    = logic,
  parameter int unsigned TIMEOUT_CYCLES = FSYNC_TX_TIMEOUT_DFLT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_empty_i,
  input  fsync_rsp_t en_rsp_i,
  output logic       en_pop_o,
  output fsync_rsp_t en_rsp_o,
  output logic       en_valid_o,
  input  logic       en_ready_i,
  output logic       en_timeout_o,
  input  logic       ws_empty_i,
  input  fsync_rsp_t ws_rsp_i,
  output logic       ws_pop_o,
  output fsync_rsp_t ws_rsp_o,
  output logic       ws_valid_o,
  input  logic       ws_ready_i,
  output logic       ws_timeout_o,
  input  logic       clr_timeout_i
);

  fractal_sync_tx_drain_ch #(
    .fsync_rsp_t   (fsync_rsp_t),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) i_en_ch (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .empty_i      (en_empty_i),
    .rsp_i        (en_rsp_i),
    .pop_o        (en_pop_o),
    .rsp_o        (en_rsp_o),
    .valid_o      (en_valid_o),
    .ready_i      (en_ready_i),
    .timeout_o    (en_timeout_o),
    .clr_timeout_i(clr_timeout_i)
  );

  fractal_sync_tx_drain_ch #(
    .fsync_rsp_t   (fsync_rsp_t),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) i_ws_ch (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .empty_i      (ws_empty_i),
    .rsp_i        (ws_rsp_i),
    .pop_o        (ws_pop_o),
    .rsp_o        (ws_rsp_o),
    .valid_o      (ws_valid_o),
    .ready_i      (ws_ready_i),
    .timeout_o    (ws_timeout_o),
    .clr_timeout_i(clr_timeout_i)
  );

endmodule

// File: tb/tb_fractal_sync_tx_drain.sv
// Directed bench for fractal_sync_tx_drain with queue-modelled response FIFOs
// and a 4-cycle watchdog.
module tb_fractal_sync_tx_drain;

  typedef struct packed {
    logic       wake;
    logic [1:0] dst;
    logic       error;
  } rsp_t;

  logic clk, rst_n;
  logic en_empty, en_pop, en_valid, en_ready, en_timeout;
  logic ws_empty, ws_pop, ws_valid, ws_ready, ws_timeout;
  logic clr_timeout;
  rsp_t en_rsp_in, en_rsp_out, ws_rsp_in, ws_rsp_out;

  rsp_t en_q[$];
  rsp_t ws_q[$];

  int checks = 0;
  int errors = 0;

  localparam rsp_t RSP_S = '{wake: 1'b1, dst: 2'd3, error: 1'b0};
  localparam rsp_t RSP_A = '{wake: 1'b1, dst: 2'd1, error: 1'b0};
  localparam rsp_t RSP_B = '{wake: 1'b0, dst: 2'd2, error: 1'b1};
  localparam rsp_t RSP_C = '{wake: 1'b1, dst: 2'd0, error: 1'b1};
  localparam rsp_t RSP_X = '{wake: 1'b0, dst: 2'd3, error: 1'b1};
  localparam rsp_t RSP_E = '{wake: 1'b1, dst: 2'd2, error: 1'b0};
  localparam rsp_t RSP_W = '{wake: 1'b0, dst: 2'd1, error: 1'b1};
  localparam rsp_t RSP_Y = '{wake: 1'b1, dst: 2'd1, error: 1'b1};

  fractal_sync_tx_drain #(
    .fsync_rsp_t   (rsp_t),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_empty_i   (en_empty),
    .en_rsp_i     (en_rsp_in),
    .en_pop_o     (en_pop),
    .en_rsp_o     (en_rsp_out),
    .en_valid_o   (en_valid),
    .en_ready_i   (en_ready),
    .en_timeout_o (en_timeout),
    .ws_empty_i   (ws_empty),
    .ws_rsp_i     (ws_rsp_in),
    .ws_pop_o     (ws_pop),
    .ws_rsp_o     (ws_rsp_out),
    .ws_valid_o   (ws_valid),
    .ws_ready_i   (ws_ready),
    .ws_timeout_o (ws_timeout),
    .clr_timeout_i(clr_timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO model drivers
  task automatic refresh();
    en_empty  = (en_q.size() == 0);
    en_rsp_in = en_empty ? rsp_t'('0) : en_q[0];
    ws_empty  = (ws_q.size() == 0);
    ws_rsp_in = ws_empty ? rsp_t'('0) : ws_q[0];
  endtask

  task automatic push_en(input rsp_t r);
    en_q.push_back(r);
    refresh();
  endtask

  task automatic push_ws(input rsp_t r);
    ws_q.push_back(r);
    refresh();
  endtask

  // Advance one clock: pops seen just before the edge retire the FIFO heads.
  task automatic cyc();
    logic pe, pw;
    pe = en_pop;
    pw = ws_pop;
    @(posedge clk);
    #1;
    if (pe && en_q.size() > 0) void'(en_q.pop_front());
    if (pw && ws_q.size() > 0) void'(ws_q.pop_front());
    refresh();
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    en_ready    = 1'b0;
    ws_ready    = 1'b0;
    clr_timeout = 1'b0;
    refresh();

    #12;
    check("rst_en_valid", 32'(en_valid), 32'd0);
    check("rst_ws_valid", 32'(ws_valid), 32'd0);
    check("rst_en_rsp", 32'(en_rsp_out), 32'd0);
    check("rst_en_pop", 32'(en_pop), 32'd0);
    check("rst_en_timeout", 32'(en_timeout), 32'd0);
    check("rst_ws_timeout", 32'(ws_timeout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // single response
    en_ready = 1'b1;
    ws_ready = 1'b1;
    push_en(RSP_S);
    #1;
    check("single_pop", 32'(en_pop), 32'd1);
    check("single_valid_before", 32'(en_valid), 32'd0);
    check("single_ws_pop", 32'(ws_pop), 32'd0);
    cyc();
    check("single_valid", 32'(en_valid), 32'd1);
    check("single_rsp", 32'(en_rsp_out), 32'(RSP_S));
    check("single_pop_after", 32'(en_pop), 32'd0);
    check("single_ws_quiet", 32'(ws_valid), 32'd0);
    cyc();
    check("single_valid_drop", 32'(en_valid), 32'd0);

    // backpressure with three queued entries
    en_ready = 1'b0;
    push_en(RSP_A);
    push_en(RSP_B);
    push_en(RSP_C);
    #1;
    check("bp_first_pop", 32'(en_pop), 32'd1);
    cyc();
    check("bp_valid", 32'(en_valid), 32'd1);
    check("bp_rsp_a", 32'(en_rsp_out), 32'(RSP_A));
    for (int i = 1; i <= 4; i++) begin
      check("bp_no_pop", 32'(en_pop), 32'd0);
      cyc();
      check("bp_hold_valid", 32'(en_valid), 32'd1);
      check("bp_hold_rsp", 32'(en_rsp_out), 32'(RSP_A));
      check("bp_timeout", 32'(en_timeout), (i == 4) ? 32'd1 : 32'd0);
    end
    check("bp_fifo_depth", 32'(en_q.size()), 32'd2);
    en_ready = 1'b1;
    #1;
    check("bp_reload_pop", 32'(en_pop), 32'd1);
    cyc();
    check("bp_valid_b", 32'(en_valid), 32'd1);
    check("bp_rsp_b", 32'(en_rsp_out), 32'(RSP_B));
    check("bp_pop_c", 32'(en_pop), 32'd1);
    cyc();
    check("bp_valid_c", 32'(en_valid), 32'd1);
    check("bp_rsp_c", 32'(en_rsp_out), 32'(RSP_C));
    check("bp_pop_empty", 32'(en_pop), 32'd0);
    cyc();
    check("bp_drained", 32'(en_valid), 32'd0);
    check("bp_timeout_sticky", 32'(en_timeout), 32'd1);
    clr_timeout = 1'b1;
    cyc();
    clr_timeout = 1'b0;
    check("bp_timeout_clr", 32'(en_timeout), 32'd0);
    cyc();
    check("bp_timeout_stays", 32'(en_timeout), 32'd0);

    // ws watchdog and re-set while stalled
    ws_ready = 1'b0;
    push_ws(RSP_X);
    #1;
    cyc();
    check("to_valid", 32'(ws_valid), 32'd1);
    check("to_rsp", 32'(ws_rsp_out), 32'(RSP_X));
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("to_rise", 32'(ws_timeout), (i == 4) ? 32'd1 : 32'd0);
      check("to_rsp_hold", 32'(ws_rsp_out), 32'(RSP_X));
    end
    check("to_en_quiet", 32'(en_timeout), 32'd0);
    clr_timeout = 1'b1;
    cyc();
    clr_timeout = 1'b0;
    check("to_clr_wins", 32'(ws_timeout), 32'd0);
    cyc();
    check("to_reset_flag", 32'(ws_timeout), 32'd1);
    check("to_still_valid", 32'(ws_valid), 32'd1);
    ws_ready = 1'b1;
    #1;
    cyc();
    check("to_handshake", 32'(ws_valid), 32'd0);
    check("to_sticky", 32'(ws_timeout), 32'd1);
    clr_timeout = 1'b1;
    cyc();
    clr_timeout = 1'b0;
    check("to_cleared", 32'(ws_timeout), 32'd0);
    cyc();
    check("to_stays_clear", 32'(ws_timeout), 32'd0);

    // concurrent load, en drains while ws holds
    en_ready = 1'b1;
    ws_ready = 1'b0;
    push_en(RSP_E);
    push_ws(RSP_W);
    #1;
    check("cc_en_pop", 32'(en_pop), 32'd1);
    check("cc_ws_pop", 32'(ws_pop), 32'd1);
    cyc();
    check("cc_en_rsp", 32'(en_rsp_out), 32'(RSP_E));
    check("cc_ws_rsp", 32'(ws_rsp_out), 32'(RSP_W));
    check("cc_ws_valid", 32'(ws_valid), 32'd1);
    cyc();
    check("cc_en_done", 32'(en_valid), 32'd0);
    check("cc_ws_hold", 32'(ws_valid), 32'd1);
    check("cc_ws_rsp_hold", 32'(ws_rsp_out), 32'(RSP_W));

    // asynchronous reset while FULL and timed out
    repeat (4) cyc();
    check("rm_timeout_set", 32'(ws_timeout), 32'd1);
    check("rm_en_timeout", 32'(en_timeout), 32'd0);
    push_ws(RSP_Y);
    #1;
    check("rm_no_pop_full", 32'(ws_pop), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rm_valid_low", 32'(ws_valid), 32'd0);
    check("rm_timeout_low", 32'(ws_timeout), 32'd0);
    check("rm_rsp_zero", 32'(ws_rsp_out), 32'd0);
    check("rm_no_pop_rst", 32'(ws_pop), 32'd0);
    cyc();
    check("rm_fifo_kept", 32'(ws_q.size()), 32'd1);
    rst_n = 1'b1;
    #1;
    check("rm_pop_after", 32'(ws_pop), 32'd1);
    cyc();
    check("rm_valid_y", 32'(ws_valid), 32'd1);
    check("rm_rsp_y", 32'(ws_rsp_out), 32'(RSP_Y));
    ws_ready = 1'b1;
    #1;
    cyc();
    check("rm_drained", 32'(ws_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
